// File: rtl/mod_div4_seq_pkg.sv
// Shared constants and types for the sequential restoring divider.
package mod_div4_seq_pkg;

    localparam int DIV_WIDTH = 4;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    // Wide enough for any supported WIDTH; truncate at the use site.
    localparam logic [31:0] DBZ_QUOT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mod_div4_seq_if.sv
// Operand/result handshake bundle between the divider and its neighbours.
interface mod_div4_seq_if
    import mod_div4_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_quot;
    logic [WIDTH-1:0] o_rem;
    logic             o_dbz;

    modport slave (
        input  i_valid, i_dividend, i_divisor, i_ready,
        output o_ready, o_valid, o_quot, o_rem, o_dbz
    );

    modport master (
        output i_valid, i_dividend, i_divisor, i_ready,
        input  o_ready, o_valid, o_quot, o_rem, o_dbz
    );
endinterface

// File: rtl/mod_div4_seq_step.sv
// One restoring-division step: ripple trial subtract of the divisor from
// {R, next dividend bit}, then keep the difference or restore.
module mod_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module mod_div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] t;
    logic [WIDTH:0]   bw;
    logic             borrow;

    assign s     = {rem, bit_in};
    assign bw[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        mod_sub_cell u_cell (
            .a    (s[i]),
            .b    (divisor[i]),
            .bin  (bw[i]),
            .diff (t[i]),
            .bout (bw[i+1])
        );
    end

    // Top subtrahend bit is zero, so the MSB cell reduces to its borrow term.
    assign borrow   = ~s[WIDTH] & bw[WIDTH];
    assign qbit     = ~borrow;
    assign rem_next = borrow ? s[WIDTH-1:0] : t;
endmodule

// File: rtl/mod_div4_seq.sv
// Sequential restoring unsigned divider, one quotient bit per clock, MSB first.
// Optional DIV_FASTPATH_EN: dividend<divisor or divisor==1 finish on the accept edge.
module mod_div4_seq
    import mod_div4_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mod_div4_seq_if.slave   bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] dvs_q, sh_q, rem_q, quot_q, remo_q;
    logic             dbz_q;
    logic [CW-1:0]    cnt_q;

    logic             accept, dbz_hit, fast_hit;
    logic [WIDTH-1:0] fast_quot, fast_rem;
    logic [WIDTH-1:0] rem_nx;
    logic             qbit;

    assign accept  = bus.i_valid & bus.o_ready;
    assign dbz_hit = (bus.i_divisor == '0);

`ifdef DIV_FASTPATH_EN
    logic small;
    assign small     = (bus.i_dividend < bus.i_divisor);
    assign fast_hit  = ~dbz_hit & (small | (bus.i_divisor == WIDTH'(1)));
    assign fast_quot = small ? '0 : bus.i_dividend;
    assign fast_rem  = small ? bus.i_dividend : '0;
`else
    assign fast_hit  = 1'b0;
    assign fast_quot = '0;
    assign fast_rem  = '0;
`endif

    mod_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .bit_in   (sh_q[WIDTH-1]),
        .divisor  (dvs_q),
        .rem_next (rem_nx),
        .qbit     (qbit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = (dbz_hit || fast_hit) ? ST_DONE : ST_RUN;
            ST_RUN:  if (cnt_q == '0) state_nx = ST_DONE;
            ST_DONE: if (bus.i_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_ready = (state == ST_IDLE);
        bus.o_valid = (state == ST_DONE);
    end

    assign bus.o_quot = quot_q;
    assign bus.o_rem  = remo_q;
    assign bus.o_dbz  = dbz_q;

    // Shift register starts as the dividend and fills with quotient bits at the LSB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dvs_q  <= '0;
            sh_q   <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            remo_q <= '0;
            dbz_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    dvs_q <= bus.i_divisor;
                    sh_q  <= bus.i_dividend;
                    rem_q <= '0;
                    cnt_q <= CW'(WIDTH - 1);
                    if (dbz_hit) begin
                        quot_q <= WIDTH'(DBZ_QUOT);
                        remo_q <= bus.i_dividend;
                        dbz_q  <= 1'b1;
                    end else if (fast_hit) begin
                        quot_q <= fast_quot;
                        remo_q <= fast_rem;
                        dbz_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sh_q  <= {sh_q[WIDTH-2:0], qbit};
                    rem_q <= rem_nx;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quot_q <= {sh_q[WIDTH-2:0], qbit};
                        remo_q <= rem_nx;
                        dbz_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_div4_seq.sv
// Directed and exhaustive checks of mod_div4_seq (WIDTH=4) against hand values and a / % model.
module tb_mod_div4_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

`ifdef DIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    mod_div4_seq_if #(.WIDTH(4)) bus ();

    mod_div4_seq #(.WIDTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int exp_lat(input int a, input int b);
        if (b == 0) return 1;
        if (FAST && (a < b || b == 1)) return 1;
        return 5;
    endfunction

    // Issue one operation, check latency and result, optionally stall the result.
    task automatic div_op(input logic [3:0] a, input logic [3:0] b, input int stall,
                          input logic [3:0] eq, input logic [3:0] er, input logic ed,
                          input int elat, input string tag);
        int n;
        check({tag, ".rdy"}, bus.o_ready, 1);
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_valid    = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        n = 1;
        while (!bus.o_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".lat"}, n, elat);
        check({tag, ".quot"}, bus.o_quot, eq);
        check({tag, ".rem"}, bus.o_rem, er);
        check({tag, ".dbz"}, bus.o_dbz, ed);
        if (stall > 0) begin
            bus.i_ready = 1'b0;
            for (int k = 0; k < stall; k++) begin
                bus.i_valid    = ~k[0];
                bus.i_dividend = 4'hF;
                bus.i_divisor  = 4'h1;
                @(posedge clk); #1;
                check({tag, ".hold_vld"}, bus.o_valid, 1);
                check({tag, ".hold_rdy"}, bus.o_ready, 0);
                check({tag, ".hold_q"}, bus.o_quot, eq);
                check({tag, ".hold_r"}, bus.o_rem, er);
            end
            bus.i_valid = 1'b0;
            bus.i_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, ".drop"}, bus.o_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.i_valid    = 1'b0;
        bus.i_ready    = 1'b1;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        #2;
        check("rst.rdy", bus.o_ready, 1);
        check("rst.vld", bus.o_valid, 0);
        check("rst.quot", bus.o_quot, 0);
        check("rst.rem", bus.o_rem, 0);
        check("rst.dbz", bus.o_dbz, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        div_op(4'd13, 4'd3, 0, 4'd4, 4'd1, 1'b0, exp_lat(13, 3), "d13_3");
        div_op(4'd15, 4'd15, 0, 4'd1, 4'd0, 1'b0, exp_lat(15, 15), "d15_15");
        div_op(4'd15, 4'd1, 0, 4'd15, 4'd0, 1'b0, exp_lat(15, 1), "d15_1");
        div_op(4'd7, 4'd0, 0, 4'd15, 4'd7, 1'b1, 1, "d7_0");
        div_op(4'd9, 4'd4, 10, 4'd2, 4'd1, 1'b0, exp_lat(9, 4), "d9_4");

        // Reset two edges into an operation; outputs clear without a clock edge.
        bus.i_dividend = 4'd11;
        bus.i_divisor  = 4'd2;
        bus.i_valid    = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst.rdy", bus.o_ready, 1);
        check("mid_rst.vld", bus.o_valid, 0);
        check("mid_rst.quot", bus.o_quot, 0);
        check("mid_rst.rem", bus.o_rem, 0);
        check("mid_rst.dbz", bus.o_dbz, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        div_op(4'd11, 4'd2, 0, 4'd5, 4'd1, 1'b0, exp_lat(11, 2), "d11_2");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                div_op(4'(a), 4'(b), int'($urandom_range(0, 2)),
                       (b == 0) ? 4'hF : 4'(a / b),
                       (b == 0) ? 4'(a) : 4'(a % b),
                       (b == 0), exp_lat(a, b), $sformatf("ex%0d_%0d", a, b));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
